// File: rtl/mvu_apb_csr_bank.sv
// mvu_apb_csr_bank: APB3 slave holding per-MVU configuration registers.
// Adds readback, wait states, error responses, byte strobes, broadcast writes,
// and per-MVU busy/done tracking that gates the start pulse.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   psel/penable/pwrite/paddr/
//   pwdata/pstrb                  APB request; paddr[11:2] reg index, paddr[11+BMVUA:12] MVU id
//   prdata/pready/pslverr         registered APB response, nonzero only in the commit cycle
//   cfg_o                         flattened config bus, MVU k reg r at (k*NREGS+r)*REG_W
//   start_o                       one-cycle launch pulse per MVU
//   done_i                        one-cycle completion pulse per MVU
//   irq_o                         level interrupt per MVU (sticky done bit)
module mvu_apb_csr_bank #(
    parameter int unsigned NMVU        = 8,
    parameter int unsigned BMVUA       = 3,
    parameter int unsigned NREGS       = 64,
    parameter int unsigned REG_W       = 32,
    parameter int unsigned CMD_IDX     = 62,
    parameter int unsigned STATUS_IDX  = 63,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          BCAST_EN    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [12+BMVUA-1:0]         paddr,
    input  logic [31:0]                 pwdata,
    input  logic [3:0]                  pstrb,
    output logic [31:0]                 prdata,
    output logic                        pready,
    output logic                        pslverr,
    output logic [NMVU*NREGS*REG_W-1:0] cfg_o,
    output logic [NMVU-1:0]             start_o,
    input  logic [NMVU-1:0]             done_i,
    output logic [NMVU-1:0]             irq_o
);

    localparam int unsigned AW    = 12 + BMVUA;
    localparam int unsigned CFG_W = NMVU * NREGS * REG_W;
    localparam logic [2:0]  WAIT_C = 3'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, state_d;
    logic [2:0]            cnt, cnt_d;
    logic                  pready_d, pslverr_d;
    logic [31:0]           prdata_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [NMVU-1:0]       busy, busy_d, done, done_d, start_q, start_d;
    logic [NMVU-1:0]       busy_eff;

    logic [9:0]            reg_idx;
    logic [BMVUA-1:0]      mvu_id;
    logic                  bcast, reg_ok, id_ok, is_cmd, is_status, err_c;
    logic                  sel_busy, sel_done, sel_busy_eff;
    logic [REG_W-1:0]      sel_cfg;
    logic [31:0]           rdata_c, wmask;
    logic                  enter_commit, commit, wr_commit;
    int unsigned           off;
    logic                  unused_addr_bits;

    assign reg_idx          = paddr[11:2];
    assign mvu_id           = paddr[AW-1:12];
    assign unused_addr_bits = ^paddr[1:0];
    // A done pulse retires the MVU before any same-cycle CMD is judged.
    assign busy_eff         = busy & ~done_i;
    assign wmask            = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};

    // Address decode, error classification and read-data mux.
    always_comb begin
        bcast        = BCAST_EN && (mvu_id == {BMVUA{1'b1}});
        reg_ok       = 32'(reg_idx) < NREGS;
        id_ok        = (32'(mvu_id) < NMVU) && !bcast;
        is_cmd       = reg_idx == 10'(CMD_IDX);
        is_status    = reg_idx == 10'(STATUS_IDX);
        sel_busy     = 1'b0;
        sel_done     = 1'b0;
        sel_busy_eff = 1'b0;
        sel_cfg      = '0;
        for (int k = 0; k < NMVU; k++) begin
            if (mvu_id == BMVUA'(k)) begin
                sel_busy     = busy[k];
                sel_done     = done[k];
                sel_busy_eff = busy_eff[k];
                sel_cfg      = cfg_q[(32'(k) * NREGS + (reg_ok ? 32'(reg_idx) : 32'd0)) * REG_W +: REG_W];
            end
        end
        err_c   = !reg_ok
               || (bcast ? !pwrite : !id_ok)
               || (id_ok && pwrite && is_cmd && sel_busy_eff);
        rdata_c = is_status ? {30'b0, sel_done, sel_busy} : 32'(sel_cfg);
    end

    // Transfer FSM: the response is registered on entry to the commit cycle.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        prdata_d     = '0;
        enter_commit = 1'b0;
        case (state)
            IDLE: begin
                if (psel && penable) begin
                    state_d      = ACCESS;
                    cnt_d        = '0;
                    enter_commit = (WAIT_CYCLES == 0);
                end
            end
            ACCESS: begin
                if (!psel || pready) begin
                    state_d = IDLE;
                end else begin
                    cnt_d        = cnt + 3'd1;
                    enter_commit = (cnt_d == WAIT_C);
                end
            end
        endcase
        if (enter_commit) begin
            pready_d  = 1'b1;
            pslverr_d = err_c;
            prdata_d  = (!pwrite && !err_c) ? rdata_c : 32'd0;
        end
    end

    assign commit    = (state == ACCESS) && pready && psel;
    assign wr_commit = commit && pwrite && !pslverr;

    // Storage, busy/done and start updates applied at the end of the commit cycle.
    always_comb begin
        cfg_d   = cfg_q;
        busy_d  = busy_eff;
        done_d  = done | done_i;
        start_d = '0;
        off     = 0;
        if (wr_commit) begin
            for (int k = 0; k < NMVU; k++) begin
                if (bcast || (mvu_id == BMVUA'(k))) begin
                    if (is_status) begin
                        // W1C on done; a coincident done pulse keeps it set.
                        if (pwdata[1]) done_d[k] = done_i[k];
                    end else if (!(is_cmd && busy_eff[k])) begin
                        off = (32'(k) * NREGS + 32'(reg_idx)) * REG_W;
                        cfg_d[off +: REG_W] = REG_W'((32'(cfg_q[off +: REG_W]) & ~wmask) | (pwdata & wmask));
                        if (is_cmd) begin
                            busy_d[k]  = 1'b1;
                            start_d[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            cfg_q   <= '0;
            busy    <= '0;
            done    <= '0;
            start_q <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
            cfg_q   <= cfg_d;
            busy    <= busy_d;
            done    <= done_d;
            start_q <= start_d;
        end
    end

    assign cfg_o   = cfg_q;
    assign start_o = start_q;
    assign irq_o   = done;

endmodule

// File: tb/tb_mvu_apb_csr_bank.sv
// Directed bench for mvu_apb_csr_bank: u0 is a 8-MVU bank with two wait states
// and a 4-bit MVU field (broadcast id 15); u1 is a 2-MVU bank with 16-bit registers.
module tb_mvu_apb_csr_bank;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0]        paddr = '0;
    logic [31:0]        pwdata = '0;
    logic [3:0]         pstrb = '0;
    logic [31:0]        prdata0, prdata1;
    logic               pready0, pready1, pslverr0, pslverr1;
    logic [8*64*32-1:0] cfg0;
    logic [2*64*16-1:0] cfg1;
    logic [7:0]         start0, irq0, done0 = '0;
    logic [1:0]         start1, irq1;
    logic [1:0]         done1 = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mvu_apb_csr_bank #(.NMVU(8), .BMVUA(4), .NREGS(64), .REG_W(32), .CMD_IDX(62),
                       .STATUS_IDX(63), .WAIT_CYCLES(2), .BCAST_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
        .pready(pready0), .pslverr(pslverr0), .cfg_o(cfg0), .start_o(start0),
        .done_i(done0), .irq_o(irq0));

    mvu_apb_csr_bank #(.NMVU(2), .BMVUA(2), .NREGS(64), .REG_W(16), .CMD_IDX(62),
                       .STATUS_IDX(63), .WAIT_CYCLES(0), .BCAST_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr[13:0]), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1),
        .pready(pready1), .pslverr(pslverr1), .cfg_o(cfg1), .start_o(start1),
        .done_i(done1), .irq_o(irq1));

    // One APB transfer; dcommit is driven on done0 during the commit cycle.
    task automatic apb(input bit inst, input bit wr, input logic [15:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [7:0] dcommit,
                       output logic [31:0] rd, output logic err, output int n, output logic [7:0] st);
        logic rdy;
        @(posedge clk); #1;
        if (inst) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 1;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
            rdy = inst ? pready1 : pready0;
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL apb_timeout addr=%h no pready after %0d cycles", addr, n);
        end
        rd  = inst ? prdata1 : prdata0;
        err = inst ? pslverr1 : pslverr0;
        done0 = dcommit;
        @(posedge clk); #1;
        done0 = '0;
        st = start0;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_done(input logic [7:0] v);
        @(posedge clk); #1; done0 = v;
        @(posedge clk); #1; done0 = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b%b want=00", pready0, pslverr0); end
        total++; if (prdata0 !== 32'h0) begin bad++; $display("FAIL reset_prdata got=%h want=0", prdata0); end
        total++; if (cfg0 !== '0 || cfg1 !== '0) begin bad++; $display("FAIL reset_cfg got nonzero want=0"); end
        total++; if (start0 !== 8'h0 || irq0 !== 8'h0 || start1 !== 2'b0 || irq1 !== 2'b0) begin bad++; $display("FAIL reset_start_irq got=%h %h want=0 0", start0, irq0); end
        rst = 1'b0;
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; logic err; int n; logic [7:0] st;
        apb(0, 1, 16'h1014, 32'hDEADBEEF, 4'hF, 8'h0, rd, err, n, st);
        total++; if (n !== 4) begin bad++; $display("FAIL wr_latency got=%0d want=4", n); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
        total++; if (cfg0[69*32 +: 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_cfg got=%h want=deadbeef", cfg0[69*32 +: 32]); end
        apb(0, 0, 16'h1014, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin bad++; $display("FAIL rd_back got=%h err=%b want=deadbeef err=0", rd, err); end
        total++; if (n !== 4) begin bad++; $display("FAIL rd_latency got=%0d want=4", n); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int n; logic [7:0] st;
        apb(0, 1, 16'h1018, 32'h11223344, 4'hF, 8'h0, rd, err, n, st);
        apb(0, 1, 16'h1018, 32'h0000AB00, 4'b0010, 8'h0, rd, err, n, st);
        apb(0, 0, 16'h1018, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h1122AB44) begin bad++; $display("FAIL strobe32 got=%h want=1122ab44", rd); end
        apb(1, 1, 16'h0018, 32'h11223344, 4'hF, 8'h0, rd, err, n, st);
        apb(1, 0, 16'h0018, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h00003344) begin bad++; $display("FAIL narrow_rd got=%h want=00003344", rd); end
        total++; if (n !== 2) begin bad++; $display("FAIL nowait_latency got=%0d want=2", n); end
        apb(1, 1, 16'h0018, 32'h0000AB00, 4'b0010, 8'h0, rd, err, n, st);
        apb(1, 0, 16'h0018, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h0000AB44) begin bad++; $display("FAIL narrow_strobe got=%h want=0000ab44", rd); end
        total++; if (cfg1[6*16 +: 16] !== 16'hAB44) begin bad++; $display("FAIL narrow_cfg got=%h want=ab44", cfg1[6*16 +: 16]); end
    endtask

    task automatic test_cmd();
        logic [31:0] rd; logic err; int n; logic [7:0] st;
        apb(0, 1, 16'h20F8, 32'h1, 4'hF, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b0 || st !== 8'h04) begin bad++; $display("FAIL cmd_start got err=%b start=%h want err=0 start=04", err, st); end
        @(posedge clk); #1;
        total++; if (start0 !== 8'h00) begin bad++; $display("FAIL cmd_pulse_len got=%h want=00", start0); end
        apb(0, 0, 16'h20FC, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL status_busy got=%h want=1", rd); end
        apb(0, 1, 16'h20F8, 32'h2, 4'hF, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b1 || st !== 8'h00) begin bad++; $display("FAIL cmd_busy got err=%b start=%h want err=1 start=00", err, st); end
        total++; if (cfg0[(2*64+62)*32 +: 32] !== 32'h1) begin bad++; $display("FAIL cmd_busy_nowrite got=%h want=1", cfg0[(2*64+62)*32 +: 32]); end
        pulse_done(8'h04);
        apb(0, 0, 16'h20FC, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h2 || irq0[2] !== 1'b1) begin bad++; $display("FAIL status_done got=%h irq=%b want=2 irq=1", rd, irq0[2]); end
        apb(0, 1, 16'h20FC, 32'h2, 4'hF, 8'h0, rd, err, n, st);
        apb(0, 0, 16'h20FC, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h0 || irq0[2] !== 1'b0) begin bad++; $display("FAIL status_w1c got=%h irq=%b want=0 irq=0", rd, irq0[2]); end
    endtask

    task automatic test_bcast();
        logic [31:0] rd; logic err; int n; logic [7:0] st;
        apb(0, 1, 16'h30F8, 32'h33, 4'hF, 8'h0, rd, err, n, st);
        total++; if (st !== 8'h08) begin bad++; $display("FAIL mvu3_start got=%h want=08", st); end
        apb(0, 1, 16'hF0F8, 32'h55, 4'hF, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b0 || st !== 8'hF7) begin bad++; $display("FAIL bcast_start got err=%b start=%h want err=0 start=f7", err, st); end
        apb(0, 0, 16'h30F8, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h33) begin bad++; $display("FAIL bcast_busy_keep got=%h want=33", rd); end
        apb(0, 0, 16'h00F8, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h55) begin bad++; $display("FAIL bcast_store got=%h want=55", rd); end
        apb(0, 0, 16'hF0F8, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL bcast_read got err=%b data=%h want err=1 data=0", err, rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int n; logic [7:0] st;
        apb(0, 1, 16'h8014, 32'h12345678, 4'hF, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b1 || cfg0[5*32 +: 32] !== 32'h0) begin bad++; $display("FAIL bad_mvu got err=%b mvu0r5=%h want err=1 mvu0r5=0", err, cfg0[5*32 +: 32]); end
        apb(0, 1, 16'h1118, 32'h0, 4'hF, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b1 || cfg0[70*32 +: 32] !== 32'h1122AB44) begin bad++; $display("FAIL bad_reg got err=%b mvu1r6=%h want err=1 mvu1r6=1122ab44", err, cfg0[70*32 +: 32]); end
        apb(0, 0, 16'h1118, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL bad_reg_rd got err=%b data=%h want err=1 data=0", err, rd); end
        pulse_done(8'h01);
        apb(0, 1, 16'h00FC, 32'h2, 4'hF, 8'h01, rd, err, n, st);
        apb(0, 0, 16'h00FC, 32'h0, 4'h0, 8'h0, rd, err, n, st);
        total++; if (rd !== 32'h2 || irq0[0] !== 1'b1) begin bad++; $display("FAIL done_vs_w1c got=%h irq=%b want=2 irq=1", rd, irq0[0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int n; logic [7:0] st;
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h4004; pwdata = 32'hCAFE; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        total++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0) begin bad++; $display("FAIL midrst_resp got=%b%b %h want=00 0", pready0, pslverr0, prdata0); end
        total++; if (cfg0 !== '0 || irq0 !== 8'h0 || start0 !== 8'h0) begin bad++; $display("FAIL midrst_state got irq=%h start=%h (cfg nonzero=%b) want all 0", irq0, start0, cfg0 != '0); end
        psel0 = 1'b0; penable = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) @(posedge clk);
        total++; if (cfg0[(4*64+1)*32 +: 32] !== 32'h0) begin bad++; $display("FAIL midrst_nocommit got=%h want=0", cfg0[(4*64+1)*32 +: 32]); end
        apb(0, 1, 16'h4004, 32'hBEEF, 4'hF, 8'h0, rd, err, n, st);
        total++; if (n !== 4 || err !== 1'b0 || cfg0[(4*64+1)*32 +: 32] !== 32'hBEEF) begin bad++; $display("FAIL post_rst_wr got n=%0d err=%b cfg=%h want 4 0 beef", n, err, cfg0[(4*64+1)*32 +: 32]); end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_strobe();
        test_cmd();
        test_bcast();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
